// File: rtl/uart_pkg.sv
// uart_pkg: types and default constants shared by the UART transmitter and receiver
//   state_t    : IDLE, START, DATA, STOP
//   OVERSAMPLE : default tick_os pulses per bit period
//   DATA_BITS  : default data bits per frame
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous single-bit input
//   clk : system clock
//   rst : asynchronous active-low reset, loads RST_VAL into every flop
//   d   : asynchronous input
//   q   : synchronized output
module uart_sync #(
  parameter int N = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ff <= {N{RST_VAL}};
    else ff <= {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, start + count data bits (LSB first) + stop
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   tick_os    : one-clk pulse at OVERSAMPLE x baud rate
//   rx         : asynchronous serial line, idles high
//   data_out   : last correctly framed word
//   data_valid : one-clk pulse when data_out updates
//   frame_err  : one-clk pulse when the stop bit is sampled low
//   busy       : receiver is inside a frame
module uart_rx import uart_pkg::*; #(
  parameter int count = uart_pkg::DATA_BITS,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_os,
  input  logic             rx,
  output logic [count-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = count > 1 ? $clog2(count) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(count - 1);
  state_t state, state_n;
  logic rx_s, rx_prev;
  logic [TW-1:0] tick_cnt, tick_n, tick_inc;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [count-1:0] shreg, sh_n, dout_n;
  logic dv_n, fe_n;
  uart_sync #(.N(2), .RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(rx),
    .q(rx_s)
  );
  assign busy = state != IDLE;
  assign tick_inc = tick_cnt == T_LAST ? '0 : tick_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rx_prev <= 1'b1;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      rx_prev <= rx_s;
      tick_cnt <= tick_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      data_out <= dout_n;
      data_valid <= dv_n;
      frame_err <= fe_n;
    end
  // Start is timed to the middle of the start bit; from there every
  // OVERSAMPLE ticks lands in the middle of the next bit, so DATA and STOP
  // sample at the counter's terminal value. STOP returns to IDLE at mid
  // stop bit so an immediately following start edge is still caught.
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    bit_n = bit_cnt;
    sh_n = shreg;
    dout_n = data_out;
    dv_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE:
        if (rx_prev && !rx_s) begin
          state_n = START;
          tick_n = '0;
        end
      START:
        if (tick_os) begin
          if (tick_cnt == T_HALF) begin
            state_n = rx_s ? IDLE : DATA;
            tick_n = '0;
            bit_n = '0;
          end else tick_n = tick_cnt + 1'b1;
        end
      DATA:
        if (tick_os) begin
          tick_n = tick_inc;
          if (tick_cnt == T_LAST) begin
            sh_n = {rx_s, shreg[count-1:1]};
            state_n = bit_cnt == B_LAST ? STOP : DATA;
            bit_n = bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
          end
        end
      STOP:
        if (tick_os) begin
          tick_n = tick_inc;
          if (tick_cnt == T_LAST) begin
            state_n = IDLE;
            dout_n = rx_s ? shreg : data_out;
            dv_n = rx_s;
            fe_n = !rx_s;
          end
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the existing uart_tx.
- Recovers 8N1-style frames (1 start bit, `count` data bits LSB-first, 1 stop bit) from the serial line `rx`.
- Samples on a 16x-oversampled tick from the shared baud generator.
- Presents each received word with a one-cycle valid strobe, and flags framing errors.

Parameters:
- count, 8: data bits per frame; width of data_out.
- OVERSAMPLE, 16: tick_os pulses per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset, asynchronous, active-low.
- tick_os  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  count  last correctly framed word; holds its value until the next valid frame.
- data_valid  output  1  one-clk pulse when data_out updates.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - Synchronizer flops and the previous-rx flop are set to 1.
  - Tick counter, bit counter and shift register are cleared.
  - Reset asserted mid-frame aborts the frame with no valid or error pulse.
- rx input:
  - Passes through a 2-flop synchronizer; rx_s is the synchronized value.
  - A previous-value flop on rx_s gives falling-edge detection.
  - Added latency is 2 clk, which the tick timing tolerates.
- Counters:
  - tick_cnt has width $clog2(OVERSAMPLE); bit_cnt has width $clog2(count).
  - Both advance only on tick_os.
  - Both wrap to 0 explicitly at their terminal values; no reliance on natural overflow.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Falling edge on rx_s (previous=1, current=0) moves to START with tick_cnt=0.
  - A line held low never triggers a start; it must return high first.
- START:
  - On the tick_os where tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: glitch; return to IDLE with no output activity.
- DATA:
  - On each tick_os where tick_cnt==OVERSAMPLE-1 (mid bit), shift rx_s into the MSB of the shift register (right-shift), so bits arrive LSB-first.
  - After that sample, when bit_cnt==count-1, go to STOP; otherwise increment bit_cnt.
- STOP:
  - On the tick_os where tick_cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1: data_out <= shift register and data_valid=1 for exactly one clk, registered (the clk after the sampling edge).
  - rx_s=0: frame_err=1 for one clk; data_out is unchanged.
  - Either way, go to IDLE.
- data_valid and frame_err are never asserted together.
- Back-to-back frames: a start edge arriving right after the stop sample is accepted, because IDLE is entered at mid stop bit.
- tick_os held low stalls all counters; the FSM holds its state.
- Break (line held low):
  - Yields one frame_err.
  - No further activity until rx_s rises and then falls again.

Decomposition:
- Shared package uart_pkg:
  - state_t enum logic [1:0] {IDLE, START, DATA, STOP}, shared with uart_tx.
  - Default constants OVERSAMPLE=16 and DATA_BITS=8.
- Sub-module uart_sync: parameterizable N-flop synchronizer (default 2, reset value 1) for rx.
- Counters and the FSM stay in uart_rx.

Test Plan:
- Reset with rx=1, no ticks:
  - All outputs 0, busy=0.
  - Release rst; 100 clk of tick_os -> no data_valid.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1, LSB-first), tick_os every 4 clk, 16 ticks/bit:
  - data_valid pulses once, 1 clk wide, data_out=0xA5, frame_err stays 0.
- Two back-to-back frames 0x00 then 0xFF, no idle gap:
  - Two data_valid pulses; data_out=0x00, then 0xFF.
- rx low glitch of 3 tick periods, then high:
  - Returns to IDLE, busy drops, no data_valid, no frame_err.
- Frame 0x3C with stop bit driven 0:
  - frame_err pulses once; data_out keeps its previous value (0xFF); data_valid stays 0.
  - rx then held low 40 bit-times -> no further pulses.
  - rx raised, then a valid 0x55 frame -> data_out=0x55.
- Reset mid-frame:
  - rst=0 during bit 4 of frame 0x81 -> outputs cleared immediately (asynchronous), no pulses.
  - Following frame 0x81 after release -> data_out=0x81.
